multicycle_control: RTL and testbench

- Multi-cycle MIPS control FSM that sequences the shared datapath: a single ALU, a single memory port, IR, PC, register file.
- Replaces the single-cycle opcode decoder.
- Instruction set: R-type, lw, sw, beq, j, addi.
- Emits per-state datapath strobes and selects, handles a memory-ready handshake, and flags illegal opcodes.

---
 rtl/mc_ctrl_pkg.sv | 68 ++++++
 rtl/mc_ctrl_decode.sv | 86 ++++++++
 rtl/multicycle_control.sv | 83 ++++++++
 tb/tb_multicycle_control.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared state encoding, opcodes, datapath select codes and control bundle for the multi-cycle MIPS controller
package mc_ctrl_pkg;

   localparam logic [3:0] S_FETCH  = 4'd0;
   localparam logic [3:0] S_DECODE = 4'd1;
   localparam logic [3:0] S_MEMADR = 4'd2;
   localparam logic [3:0] S_MEMRD  = 4'd3;
   localparam logic [3:0] S_MEMWB  = 4'd4;
   localparam logic [3:0] S_MEMWR  = 4'd5;
   localparam logic [3:0] S_EXEC   = 4'd6;
   localparam logic [3:0] S_ALUWB  = 4'd7;
   localparam logic [3:0] S_BRANCH = 4'd8;
   localparam logic [3:0] S_JUMP   = 4'd9;
   localparam logic [3:0] S_ADDIEX = 4'd10;
   localparam logic [3:0] S_ADDIWB = 4'd11;
   localparam logic [3:0] S_ERROR  = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B   = 2'b00;
   localparam logic [1:0] SRCB_4   = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;
   localparam logic [1:0] SRCB_BR  = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   // first execution state reached from DECODE for a given opcode
   function automatic logic [3:0] decode_target(input logic [5:0] op);
      case (op)
         OP_RTYPE:     return S_EXEC;
         OP_LW, OP_SW: return S_MEMADR;
         OP_BEQ:       return S_BRANCH;
         OP_J:         return S_JUMP;
         OP_ADDI:      return S_ADDIEX;
         default:      return S_ERROR;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state-to-control decode; reset forces every output low
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic       rst,
   input  logic [3:0] state,
   input  logic       mem_ready,
   output ctrl_t      ctrl
);

   ctrl_t c;

   // per-state strobes and selects; FETCH only commits IR/PC once memory has delivered
   always_comb begin
      c = '0;
      case (state)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.alu_src_b = SRCB_4;
            c.alu_op    = ALU_ADD;
            c.pc_source = PCS_ALU;
            c.ir_write  = mem_ready;
            c.pc_write  = mem_ready;
         end
         S_DECODE: begin
            c.alu_src_b = SRCB_BR;
            c.alu_op    = ALU_ADD;
         end
         S_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_ADD;
         end
         S_MEMRD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 1'b1;
            c.instr_done = 1'b1;
         end
         S_MEMWR: begin
            c.mem_write  = 1'b1;
            c.iord       = 1'b1;
            c.instr_done = mem_ready;
         end
         S_EXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_B;
            c.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            c.reg_write  = 1'b1;
            c.reg_dst    = 1'b1;
            c.instr_done = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 1'b1;
            c.alu_src_b     = SRCB_B;
            c.alu_op        = ALU_SUB;
            c.pc_write_cond = 1'b1;
            c.pc_source     = PCS_ALUOUT;
            c.instr_done    = 1'b1;
         end
         S_JUMP: begin
            c.pc_write   = 1'b1;
            c.pc_source  = PCS_JUMP;
            c.instr_done = 1'b1;
         end
         S_ADDIEX: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALU_ADD;
         end
         S_ADDIWB: begin
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_ERROR: c.illegal_op = 1'b1;
         default: c = '0;
      endcase
      ctrl = rst ? '0 : c;
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM sequencing the shared ALU, memory port, IR, PC and register file
module multicycle_control
   import mc_ctrl_pkg::*;
#(
   parameter bit ILLEGAL_HALT = 1'b1
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUop,
   output logic [1:0] PCSource,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   logic [3:0] next_state;
   logic       is_sw;
   ctrl_t      ctrl;

   // next state; writeback states and unused encodings fall back to FETCH
   always_comb begin
      next_state = S_FETCH;
      case (state)
         S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: next_state = decode_target(opcode);
         S_MEMADR: next_state = is_sw ? S_MEMWR : S_MEMRD;
         S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   next_state = S_ALUWB;
         S_ADDIEX: next_state = S_ADDIWB;
         S_ERROR:  next_state = ILLEGAL_HALT ? S_ERROR : S_FETCH;
         default:  next_state = S_FETCH;
      endcase
   end

   // state register plus the lw/sw flag captured while the opcode is valid in DECODE
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         is_sw <= 1'b0;
      end else begin
         state <= next_state;
         if (state == S_DECODE) is_sw <= (opcode == OP_SW);
      end
   end

   mc_ctrl_decode u_decode (
      .rst       (rst),
      .state     (state),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign IorD        = ctrl.iord;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign IRWrite     = ctrl.ir_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign RegDst      = ctrl.reg_dst;
   assign RegWrite    = ctrl.reg_write;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign ALUop       = ctrl.alu_op;
   assign PCSource    = ctrl.pc_source;
   assign instr_done  = ctrl.instr_done;
   assign illegal_op  = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: instruction-level reference model driving a halting and a non-halting controller side by side
module tb_multicycle_control;

   typedef struct packed {
      logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
      logic [1:0] asb, aop, pcs;
      logic       done, ill;
   } ctl_t;

   typedef enum logic [3:0] {
      K_FETCH, K_DEC, K_ADR, K_RD, K_RWB, K_WR, K_EXE, K_AWB, K_BEQ, K_JMP, K_IEX, K_IWB, K_ERR
   } step_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mem_ready = 1'b1;
   logic [5:0] opcode = 6'd0;

   logic       h_pcw, h_pcwc, h_iord, h_mrd, h_mwr, h_irw, h_m2r, h_rdst, h_rw, h_asa, h_done, h_ill;
   logic [1:0] h_asb, h_aop, h_pcs;
   logic [3:0] h_st;
   logic       c_pcw, c_pcwc, c_iord, c_mrd, c_mwr, c_irw, c_m2r, c_rdst, c_rw, c_asa, c_done, c_ill;
   logic [1:0] c_asb, c_aop, c_pcs;
   logic [3:0] c_st;

   ctl_t obs_h, obs_c;
   assign obs_h = {h_pcw, h_pcwc, h_iord, h_mrd, h_mwr, h_irw, h_m2r, h_rdst, h_rw, h_asa, h_asb, h_aop, h_pcs, h_done, h_ill};
   assign obs_c = {c_pcw, c_pcwc, c_iord, c_mrd, c_mwr, c_irw, c_m2r, c_rdst, c_rw, c_asa, c_asb, c_aop, c_pcs, c_done, c_ill};

   int    compared = 0;
   int    mismatched = 0;
   int    cyc_n = 0;
   int    done_at = -1;
   step_t seq[$];

   always #5 clk = ~clk;

   multicycle_control #(.ILLEGAL_HALT(1'b1)) dut_h (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(h_pcw), .PCWriteCond(h_pcwc), .IorD(h_iord), .MemRead(h_mrd), .MemWrite(h_mwr),
      .IRWrite(h_irw), .MemtoReg(h_m2r), .RegDst(h_rdst), .RegWrite(h_rw), .ALUSrcA(h_asa),
      .ALUSrcB(h_asb), .ALUop(h_aop), .PCSource(h_pcs), .instr_done(h_done), .illegal_op(h_ill),
      .state(h_st)
   );

   multicycle_control #(.ILLEGAL_HALT(1'b0)) dut_c (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(c_pcw), .PCWriteCond(c_pcwc), .IorD(c_iord), .MemRead(c_mrd), .MemWrite(c_mwr),
      .IRWrite(c_irw), .MemtoReg(c_m2r), .RegDst(c_rdst), .RegWrite(c_rw), .ALUSrcA(c_asa),
      .ALUSrcB(c_asb), .ALUop(c_aop), .PCSource(c_pcs), .instr_done(c_done), .illegal_op(c_ill),
      .state(c_st)
   );

   // control values the datapath needs during each step of an instruction
   function automatic ctl_t expv(input step_t s, input logic mr);
      ctl_t e = '0;
      case (s)
         K_FETCH: begin e.mrd = 1; e.asb = 2'b01; e.irw = mr; e.pcw = mr; end
         K_DEC:   e.asb = 2'b11;
         K_ADR:   begin e.asa = 1; e.asb = 2'b10; end
         K_RD:    begin e.mrd = 1; e.iord = 1; end
         K_RWB:   begin e.rw = 1; e.m2r = 1; e.done = 1; end
         K_WR:    begin e.mwr = 1; e.iord = 1; e.done = mr; end
         K_EXE:   begin e.asa = 1; e.aop = 2'b10; end
         K_AWB:   begin e.rw = 1; e.rdst = 1; e.done = 1; end
         K_BEQ:   begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.pcs = 2'b01; e.done = 1; end
         K_JMP:   begin e.pcw = 1; e.pcs = 2'b10; e.done = 1; end
         K_IEX:   begin e.asa = 1; e.asb = 2'b10; end
         K_IWB:   begin e.rw = 1; e.done = 1; end
         default: e.ill = 1;
      endcase
      return e;
   endfunction

   // step list an instruction walks through
   function automatic void expand(input logic [5:0] op);
      seq = {K_FETCH, K_DEC};
      case (op)
         6'b000000: begin seq.push_back(K_EXE); seq.push_back(K_AWB); end
         6'b100011: begin seq.push_back(K_ADR); seq.push_back(K_RD); seq.push_back(K_RWB); end
         6'b101011: begin seq.push_back(K_ADR); seq.push_back(K_WR); end
         6'b000100: seq.push_back(K_BEQ);
         6'b000010: seq.push_back(K_JMP);
         6'b001000: begin seq.push_back(K_IEX); seq.push_back(K_IWB); end
         default:   seq.push_back(K_ERR);
      endcase
   endfunction

   // zero-wait latency, fetch start to instr_done inclusive
   function automatic int lat(input logic [5:0] op);
      case (op)
         6'b000000: return 4;
         6'b100011: return 5;
         6'b101011: return 4;
         6'b000100: return 3;
         6'b000010: return 3;
         6'b001000: return 4;
         default:   return 0;
      endcase
   endfunction

   function automatic logic [5:0] pick_op();
      case ($urandom_range(0, 7))
         0: return 6'b000000;
         1: return 6'b100011;
         2: return 6'b101011;
         3: return 6'b000100;
         4: return 6'b000010;
         5: return 6'b001000;
         default: return 6'($urandom);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc_n);
      end
   endtask

   // one clock: drive inputs, check both controllers mid-cycle, advance
   task automatic cyc(input step_t sh, input step_t sc, input logic mr, input logic [5:0] op, input logic r);
      rst = r;
      mem_ready = mr;
      opcode = op;
      #1;
      chk("ctrl_halt", 32'(obs_h), r ? 32'd0 : 32'(expv(sh, mr)));
      chk("ctrl_cont", 32'(obs_c), r ? 32'd0 : 32'(expv(sc, mr)));
      if (!r && sh == K_FETCH) chk("state_halt", 32'(h_st), 32'd0);
      if (!r && sc == K_FETCH) chk("state_cont", 32'(c_st), 32'd0);
      if (h_done === 1'b1 && done_at < 0) done_at = cyc_n;
      cyc_n++;
      @(negedge clk);
   endtask

   // wf/wm: fetch/memory wait cycles (-1 random); abort: step index to hit with rst (-1 none, -2 random)
   task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int abort, input int hold);
      int    waits, start, ab, w;
      step_t s;
      expand(op);
      ab = abort;
      if (ab == -2) ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, seq.size() - 1)) : -1;
      waits = 0;
      start = cyc_n;
      done_at = -1;
      foreach (seq[i]) begin
         s = seq[i];
         if (i == ab) begin
            cyc(s, s, 1'b0, 6'($urandom), 1'b1);
            return;
         end
         if (s == K_FETCH || s == K_RD || s == K_WR) begin
            w = (s == K_FETCH) ? wf : wm;
            if (w < 0) w = $urandom_range(0, 2);
            waits += w;
            repeat (w) cyc(s, s, 1'b0, 6'($urandom), 1'b0);
            cyc(s, s, 1'b1, 6'($urandom), 1'b0);
         end else if (s == K_ERR) begin
            cyc(K_ERR, K_ERR, 1'($urandom), 6'($urandom), 1'b0);
            repeat (hold) cyc(K_ERR, K_FETCH, 1'b0, 6'($urandom), 1'b0);
            cyc(K_ERR, K_FETCH, 1'b0, 6'($urandom), 1'b1);
         end else begin
            cyc(s, s, 1'($urandom), (s == K_DEC) ? op : 6'($urandom), 1'b0);
         end
      end
      if (lat(op) > 0) chk("latency", 32'(done_at - start + 1), 32'(lat(op) + waits));
   endtask

   initial begin
      @(negedge clk);
      cyc(K_FETCH, K_FETCH, 1'b1, 6'd0, 1'b1);
      chk("rst_state_halt", 32'(h_st), 32'd0);
      chk("rst_state_cont", 32'(c_st), 32'd0);
      cyc(K_FETCH, K_FETCH, 1'b1, 6'd0, 1'b1);
      chk("rst_state_halt2", 32'(h_st), 32'd0);
      run_instr(6'b000000, 0, 0, -1, 0);
      run_instr(6'b100011, 0, 2, -1, 0);
      run_instr(6'b101011, 0, 0, -1, 0);
      run_instr(6'b000100, 0, 0, -1, 0);
      run_instr(6'b000010, 0, 0, -1, 0);
      run_instr(6'b001000, 0, 0, -1, 0);
      run_instr(6'b111111, 0, 0, -1, 10);
      run_instr(6'b101011, 0, 0, 3, 0);
      run_instr(6'b000000, 5, 0, -1, 0);
      repeat (200) run_instr(pick_op(), -1, -1, -2, int'($urandom_range(0, 3)));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
